// File: rtl/lstm_input_loader.sv
// Write-side loader for the LSTM input-feature memory: streams signed feature
// words into a time-step-major array and exposes the same combinational read port.
module lstm_input_loader #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 69,
  parameter int NUM_ITERATIONS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [WIDTH-1:0] rd_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic        [6:0]       feat_idx,
  output logic        [3:0]       iter_idx,
  output logic                    step_done,
  output logic                    done
);

  localparam int DEPTH = (NUM - 1) * NUM_ITERATIONS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]              state;
  logic [AW-1:0]           wr_addr;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic                    accept;
  logic                    last_feat;
  logic                    last_word;

  assign in_ready  = (state == LOAD);
  // A start pulse in LOAD wins over a same-cycle transfer, so that word is dropped.
  assign accept    = in_ready && in_valid && !start;
  assign last_feat = (feat_idx == 7'(NUM - 2));
  assign last_word = (wr_addr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_addr   <= '0;
      feat_idx  <= '0;
      iter_idx  <= '0;
      step_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            wr_addr  <= '0;
            feat_idx <= '0;
            iter_idx <= '0;
            done     <= 1'b0;
          end
        end
        LOAD: begin
          if (start) begin
            wr_addr  <= '0;
            feat_idx <= '0;
            iter_idx <= '0;
          end else if (in_valid) begin
            wr_addr <= wr_addr + 1'b1;
            if (last_feat) begin
              feat_idx  <= '0;
              iter_idx  <= iter_idx + 4'd1;
              step_done <= 1'b1;
            end else begin
              feat_idx <= feat_idx + 7'd1;
            end
            // The final word also completes the last vector, so step_done still pulses.
            if (last_word) begin
              state    <= FULL;
              done     <= 1'b1;
              wr_addr  <= '0;
              feat_idx <= '0;
              iter_idx <= '0;
            end
          end
        end
        FULL: begin
          if (start) begin
            state    <= LOAD;
            done     <= 1'b0;
            wr_addr  <= '0;
            feat_idx <= '0;
            iter_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < WIDTH'(DEPTH)) begin
      rd_data = mem[rd_addr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_lstm_input_loader.sv
// Randomized self-checking bench for lstm_input_loader against a word-count model.
module tb_lstm_input_loader;

  localparam int WIDTH = 32;
  localparam int NUM   = 69;
  localparam int NITER = 8;
  localparam int VEC   = NUM - 1;
  localparam int DEPTH = VEC * NITER;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic        [WIDTH-1:0] rd_addr;
  logic signed [WIDTH-1:0] rd_data;
  logic        [6:0]       feat_idx;
  logic        [3:0]       iter_idx;
  logic                    step_done;
  logic                    done;

  lstm_input_loader #(.WIDTH(WIDTH), .NUM(NUM), .NUM_ITERATIONS(NITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .feat_idx(feat_idx),
    .iter_idx(iter_idx), .step_done(step_done), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: the loader is just "loading or not", a count of accepted words,
  // and a done flag; the index outputs follow from the count by division.
  logic [31:0] modelMem [DEPTH];
  bit          modelWritten [DEPTH];
  bit          modelLoading;
  bit          modelDone;
  bit          modelStep;
  int          modelCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkStatus();
    checkOutput("in_ready", 32'(in_ready), 32'(modelLoading));
    checkOutput("done", 32'(done), 32'(modelDone));
    checkOutput("step_done", 32'(step_done), 32'(modelStep));
    checkOutput("feat_idx", 32'(feat_idx), modelLoading ? 32'(modelCount % VEC) : 32'd0);
    checkOutput("iter_idx", 32'(iter_idx), modelLoading ? 32'(modelCount / VEC) : 32'd0);
  endtask

  task automatic checkRead(input int addr);
    rd_addr = 32'(addr);
    #1;
    if (modelWritten[addr]) checkOutput("rd_data", rd_data, modelMem[addr]);
  endtask

  // One clock: inputs applied before the edge, model advanced, outputs checked after.
  task automatic applyStimulus(input bit st, input bit vld, input logic [31:0] data);
    bit accepted;
    int writtenAddr;
    start    = st;
    in_valid = vld;
    in_data  = data;
    accepted = modelLoading && vld && !st;
    writtenAddr = modelCount;
    @(posedge clk);
    modelStep = 1'b0;
    if (st) begin
      modelLoading = 1'b1;
      modelDone    = 1'b0;
      modelCount   = 0;
    end else if (accepted) begin
      modelMem[writtenAddr]     = data;
      modelWritten[writtenAddr] = 1'b1;
      modelCount++;
      modelStep = (modelCount % VEC) == 0;
      if (modelCount == DEPTH) begin
        modelLoading = 1'b0;
        modelDone    = 1'b1;
        modelCount   = 0;
      end
    end
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    checkStatus();
    if (accepted) checkRead(writtenAddr);
    else checkRead($urandom_range(DEPTH - 1));
  endtask

  task automatic midCycleReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelLoading = 1'b0;
    modelDone    = 1'b0;
    modelStep    = 1'b0;
    modelCount   = 0;
    #1;
    checkStatus();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic sweepMemory();
    for (int a = 0; a < DEPTH; a++) checkRead(a);
  endtask

  initial begin
    int sent;
    int k;
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    modelLoading = 0; modelDone = 0; modelStep = 0; modelCount = 0;
    for (int a = 0; a < DEPTH; a++) modelWritten[a] = 1'b0;
    #12;
    midCycleReset();

    // in_valid in IDLE must not write
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'hDEAD_0000 + 32'(i));

    // full load with valid held high
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 32'(i));
    sweepMemory();
    checkOutput("rd_data[543]", rd_data, 32'd543);

    // in_valid in FULL must not write
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'hBEEF_0000 + 32'(i));
    sweepMemory();

    rd_addr = 32'd544;      #1; checkOutput("rd_oob_544", rd_data, 32'd0);
    rd_addr = 32'hFFFFFFFF; #1; checkOutput("rd_oob_max", rd_data, 32'd0);

    // reload from FULL with gapped valid; old word 300 stays until overwritten
    applyStimulus(1'b1, 1'b0, 32'd0);
    rd_addr = 32'd300; #1; checkOutput("rd_old_300", rd_data, 32'd300);
    sent = 0; k = 0;
    while (sent < DEPTH) begin
      bit v;
      logic [31:0] d;
      v = (k % 3 == 0) || ($urandom_range(3) == 0);
      d = $urandom;
      applyStimulus(1'b0, v, d);
      if (v) sent++;
      k++;
      if (sent == 300 && v) begin
        rd_addr = 32'd300; #1; checkOutput("rd_still_old_300", rd_data, 32'd300);
      end
    end
    sweepMemory();

    // restart mid-load: start with valid drops the word
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b1, 32'h7777_7777);
    sent = 0;
    while (sent < DEPTH) begin
      bit v;
      v = $urandom_range(3) != 0;
      applyStimulus(1'b0, v, 32'(1000 + sent));
      if (v) sent++;
    end
    rd_addr = 32'd5; #1; checkOutput("rd_restart_5", rd_data, 32'd1005);
    sweepMemory();

    // async reset partway through a load
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b1, $urandom);
    midCycleReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/lstm_input_loader.md
# lstm_input_loader

Write-side counterpart of the LSTM input-feature memory. Accepts a stream of signed feature words over a valid/ready handshake and stores them in an internal array of (NUM-1)*NUM_ITERATIONS words, in the order that the read side indexes: feature-major within a time step, time steps consecutive. It tracks feature and iteration position, flags each completed time-step vector, and raises `done` once the full sequence is resident. Its read port has the same address/data semantics as the input-feature memory, so the LSTM forward path can read from it directly.

## Interface

Parameters:
- WIDTH, 32, data and address word width
- NUM, 69, features per vector plus 1 (bias slot not stored)
- NUM_ITERATIONS, 8, time steps per sequence
- DEPTH (local), (NUM-1)*NUM_ITERATIONS = 544, stored words

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins or restarts a load
- in_data  input  WIDTH signed  feature word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a word
- rd_addr  input  WIDTH  read address, 0..DEPTH-1
- rd_data  output  WIDTH signed  combinational read data
- feat_idx  output  7  feature index of the next word to be written, 0..NUM-2
- iter_idx  output  4  time-step index of the next word to be written, 0..NUM_ITERATIONS-1
- step_done  output  1  one-cycle pulse: a complete vector was just written
- done  output  1  level: all DEPTH words written

## Operation

- States: IDLE, LOAD, FULL.
- Reset (async, rst_n=0): state IDLE, wr_addr=0, feat_idx=0, iter_idx=0, step_done=0, done=0. in_ready=0. Array contents are not reset.
- in_ready = (state == LOAD), decoded from the state register only, with no dependence on in_valid.
- IDLE: start -> LOAD, counters cleared.
- LOAD: on each edge where in_valid && in_ready:
  - mem[wr_addr] <= in_data
  - wr_addr += 1; feat_idx += 1
  - if feat_idx == NUM-2: feat_idx <= 0, iter_idx += 1, step_done <= 1
  - if wr_addr == DEPTH-1: state <= FULL, done <= 1, iter_idx <= 0, feat_idx <= 0
- In LOAD, `start` has priority over a same-cycle transfer. The counters clear to 0, that word is not written, state stays LOAD, and done stays 0.
- FULL: in_ready=0, done=1, and the array holds its contents. `start` -> LOAD, clears counters and done. The old contents stay readable until each word is overwritten.
- step_done is 0 in every cycle not described above.
- Read port:
  - rd_data = mem[rd_addr] when rd_addr < DEPTH, else 0.
  - rd_data is purely combinational and valid in every state.
- Read of an address being written on the same edge returns the old word before the edge and the new word after it.
- in_valid while in IDLE or FULL is ignored, and no write occurs.

## Timing

- start sampled at edge k -> in_ready=1 from edge k through the cycle after.
- Throughput is one word per cycle. With in_valid held high, the full load takes exactly DEPTH accepting edges after LOAD entry.
- Word n is written at its accepting edge, and rd_data reflects it in the same cycle after that edge.
- step_done goes high for exactly one cycle following the edge that accepts word index m*(NUM-1)-1, for m = 1..NUM_ITERATIONS. The final pulse coincides with the first cycle of done=1.
- done and in_ready=0 take effect in the cycle right after the last accepting edge. No extra word can be accepted.
- Async reset mid-load returns to IDLE immediately. A partial load is discarded logically, although the written words remain in the array.

## Test plan

- Reset: assert rst_n=0 mid-cycle -> in_ready, done, step_done, feat_idx, iter_idx all read 0 immediately.
- Full load: start, then stream in_data=i for i=0..543 with valid held high -> done rises after the 544th accepting edge, with no earlier than that. in_ready then drops. Sweeping rd_addr=0..543 returns i. step_done pulses 8 times, after words 67, 135, …, 543.
- Gapped valid: the same stream with in_valid toggling 1,0,0,1… -> identical contents, and feat_idx/iter_idx advance only on accepting edges.
- Restart mid-load: after 100 words, pulse start together with in_valid -> that word is dropped and counters return to 0. Reloading 544 words of 1000+i gives rd_data(5)=1005.
- Out of range and idle: rd_addr=544 and rd_addr=0xFFFFFFFF -> rd_data=0. in_valid asserted in IDLE and in FULL -> no content change and in_ready stays 0.
- Reload from FULL: start in FULL -> done=0 next cycle. Before rewriting, rd_addr=300 still returns the old value. After 301 new words it returns the new value.
